// File: rtl/mask_share_gen.sv
// Generates 2-share masked encodings of x/y plus fresh randomness for a masked
// multiplier, drawing mask triples from an LFSR-fed FIFO of precomputed entries.
module mask_share_gen #(
  parameter logic [15:0] SEED  = 16'hACE1,
  parameter int          DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       x_in,
  input  logic                       y_in,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [1:0]                 x_sh,
  output logic [1:0]                 y_sh,
  output logic                       r1,
  input  logic                       seed_load,
  input  logic [15:0]                seed_val,
  output logic [$clog2(DEPTH):0]     fill_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {FILL, RUN} state_e;

  state_e          state_q, state_d;
  logic [15:0]     lfsr_q, lfsr_d;
  logic [2:0]      mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q, count_d;
  logic            out_valid_q;
  logic [1:0]      x_sh_q, y_sh_q;
  logic            r1_q;
  logic            push, pop;
  logic [2:0]      head;

  assign pop  = in_valid & in_ready;
  assign push = !seed_load && ((count_q != CW'(DEPTH)) || pop);
  assign head = mem_q[rd_ptr_q];

  // A reseed value of zero would lock the LFSR, so fall back to SEED.
  always_comb begin
    lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    if (seed_load) lfsr_d = (seed_val == 16'h0) ? SEED : seed_val;
  end

  always_comb begin
    count_d = count_q + CW'(push) - CW'(pop);
    if (seed_load) count_d = '0;
  end

  // FSM: state register
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= FILL;
    else        state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FILL: if (!seed_load && count_d == CW'(DEPTH)) state_d = RUN;
      RUN:  if (seed_load) state_d = FILL;
      default: state_d = FILL;
    endcase
  end

  // FSM: outputs; reseed wins over any accept in the same cycle
  always_comb begin
    in_ready = (state_q == RUN) && (count_q != '0) &&
               (!out_valid_q || out_ready) && !seed_load;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q   <= SEED;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      lfsr_q  <= lfsr_d;
      count_q <= count_d;
      if (seed_load) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      end
    end
  end

  // NOTE: the storage array has no reset; occupancy is tracked by count_q,
  // so stale contents are never read and the array maps to plain RAM/flops.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= lfsr_q[2:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      x_sh_q      <= '0;
      y_sh_q      <= '0;
      r1_q        <= 1'b0;
    end else if (seed_load) begin
      out_valid_q <= 1'b0;
    end else if (pop) begin
      out_valid_q <= 1'b1;
      x_sh_q      <= {x_in ^ head[0], head[0]};
      y_sh_q      <= {y_in ^ head[1], head[1]};
      r1_q        <= head[2];
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid  = out_valid_q;
  assign x_sh       = x_sh_q;
  assign y_sh       = y_sh_q;
  assign r1         = r1_q;
  assign fill_level = count_q;

endmodule

// File: tb/tb_mask_share_gen.sv
// Randomized bench for mask_share_gen against a queue-based model of the
// LFSR-fed mask FIFO and the registered share outputs.
module tb_mask_share_gen;

  localparam logic [15:0] SEED  = 16'hACE1;
  localparam int          DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, x_in, y_in;
  logic        out_valid, out_ready, r1;
  logic [1:0]  x_sh, y_sh;
  logic        seed_load;
  logic [15:0] seed_val;
  logic [$clog2(DEPTH):0] fill_level;

  int n_checks = 0;
  int n_errors = 0;

  // model state
  logic [15:0] m_s;
  logic [2:0]  m_q [$];
  logic        m_run, m_ov, m_r;
  logic [1:0]  m_xs, m_ys;

  mask_share_gen #(.SEED(SEED), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .x_in(x_in), .y_in(y_in), .out_valid(out_valid), .out_ready(out_ready),
    .x_sh(x_sh), .y_sh(y_sh), .r1(r1), .seed_load(seed_load),
    .seed_val(seed_val), .fill_level(fill_level)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  task automatic model_reset();
    m_s = SEED;
    m_q.delete();
    m_run = 1'b0;
    m_ov = 1'b0;
    m_xs = '0;
    m_ys = '0;
    m_r = 1'b0;
  endtask

  // Called at a falling edge with inputs already applied; returns at the next falling edge.
  task automatic cycle();
    logic exp_rdy, acc;
    logic [2:0] tr;
    #1;
    exp_rdy = m_run && (m_q.size() > 0) && (!m_ov || out_ready) && !seed_load;
    check("in_ready", in_ready, exp_rdy);
    acc = in_valid && exp_rdy;
    if (seed_load) begin
      m_s = (seed_val == 16'h0) ? SEED : seed_val;
      m_q.delete();
      m_run = 1'b0;
      m_ov = 1'b0;
    end else begin
      if (acc) begin
        tr = m_q.pop_front();
        m_ov = 1'b1;
        m_xs = {x_in ^ tr[0], tr[0]};
        m_ys = {y_in ^ tr[1], tr[1]};
        m_r = tr[2];
      end else if (out_ready) begin
        m_ov = 1'b0;
      end
      if (m_q.size() < DEPTH) m_q.push_back(m_s[2:0]);
      if (m_q.size() == DEPTH) m_run = 1'b1;
      m_s = lfsr_next(m_s);
    end
    @(posedge clk);
    #1;
    check("out_valid", out_valid, m_ov);
    check("fill_level", fill_level, m_q.size());
    if (m_ov) begin
      check("x_sh", x_sh, m_xs);
      check("y_sh", y_sh, m_ys);
      check("r1", r1, m_r);
    end
    if (acc) begin
      check("x_recombine", x_sh[0] ^ x_sh[1], x_in);
      check("y_recombine", y_sh[0] ^ y_sh[1], y_in);
    end
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0; x_in = 1'b0; y_in = 1'b0;
    out_ready = 1'b0; seed_load = 1'b0; seed_val = '0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_x_sh"}, x_sh, 0);
    check({tag, "_y_sh"}, y_sh, 0);
    check({tag, "_r1"}, r1, 0);
    check({tag, "_in_ready"}, in_ready, 0);
    check({tag, "_fill_level"}, fill_level, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;

    // Fill from reset: occupancy 1..DEPTH, then ready.
    for (int i = 1; i <= DEPTH; i++) begin
      cycle();
      check("fill_count", fill_level, i);
    end

    // First accept after reset with the default seed.
    in_valid = 1'b1; x_in = 1'b1; y_in = 1'b1; out_ready = 1'b1;
    #1 check("ready_9th", in_ready, 1);
    cycle();
    check("first_x_sh", x_sh, 2'b01);
    check("first_y_sh", y_sh, 2'b10);
    check("first_r1", r1, 0);
    check("first_valid", out_valid, 1);

    // Downstream stall: outputs frozen, no accepts, FIFO stays full.
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      x_in = 1'($urandom);
      y_in = 1'($urandom);
      cycle();
      check("stall_fill", fill_level, DEPTH);
      check("stall_x_sh", x_sh, 2'b01);
    end

    // Streaming at full rate.
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      x_in = 1'($urandom);
      y_in = 1'($urandom);
      cycle();
      check("stream_fill", fill_level, DEPTH);
    end

    // Reseed with zero during an accept: accept dropped, back to default seed.
    seed_load = 1'b1; seed_val = 16'h0;
    cycle();
    check("reseed_valid", out_valid, 0);
    check("reseed_fill", fill_level, 0);
    seed_load = 1'b0;
    in_valid = 1'b0;
    for (int i = 0; i < DEPTH; i++) cycle();
    in_valid = 1'b1; x_in = 1'b1; y_in = 1'b1;
    cycle();
    check("reseed_x_sh", x_sh, 2'b01);
    check("reseed_y_sh", y_sh, 2'b10);
    check("reseed_r1", r1, 0);

    // Random traffic with occasional reseeds.
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(3) != 0);
      out_ready = ($urandom_range(3) != 0);
      x_in      = 1'($urandom);
      y_in      = 1'($urandom);
      seed_load = ($urandom_range(39) == 0);
      seed_val  = ($urandom_range(3) == 0) ? 16'h0 : 16'($urandom);
      cycle();
    end
    seed_load = 1'b0;

    // Asynchronous reset mid-stream.
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      x_in = 1'($urandom);
      y_in = 1'($urandom);
      cycle();
    end
    #2 rst_n = 1'b0;
    #1 check_all_zero("async_rst");
    model_reset();
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b1;
    cycle();
    check("refill_first", fill_level, 1);
    for (int i = 0; i < 200; i++) begin
      in_valid  = 1'($urandom);
      out_ready = 1'($urandom);
      x_in      = 1'($urandom);
      y_in      = 1'($urandom);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
